ctrl_decode_stage: RTL and testbench
====================================

Name: ctrl_decode_stage

Overview:
- Registered, parametrised successor to the single-cycle opcode control decoder. Sits between fetch and execute.
- Accepts instructions over a valid/ready handshake, decodes the opcode to a control bundle, and holds it in a pipeline register.
- Detects load-use hazards against recently issued loads and inserts a programmable number of bubbles.
- Supports flush from execute, flags illegal opcodes, and adds a distinct BRN indication.

Parameters:
- OP_W, 4, opcode width (≥4); low 4 bits are the ISA opcode, any nonzero upper bit → illegal.
- REG_W, 4, register index width.
- ALUOP_W, 3, alu_op width (≥3); codes zero-extended.
- LU_BUBBLES, 1, bubbles required between a load and a dependent instruction (1..7).
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage accepts instruction this cycle.
- op  in  OP_W  opcode.
- rs, rt, rd  in  REG_W each  source/source/dest indices.
- flush  in  1  squash stage contents (from execute, on taken branch/jump).
- out_valid  out  1  registered bundle valid.
- out_ready  in  1  downstream accepts bundle.
- reg_wrt, mem_read, mem_write, branch, br_neg, j, alu_to_reg, const_sel, pc_to_alu, jm, max_op, illegal  out  1 each  registered controls.
- alu_op  out  ALUOP_W  registered ALU operation.
- sign_extend  out  2  registered immediate mode.
- rs_q, rt_q, rd_q  out  REG_W each  registered indices.
- stall_cnt  out  CNT_W  saturating count of hazard bubbles.

Behaviour:
- Reset:
  - On a clk edge with rst=1, every registered output is 0, ld_age=0 and stall_cnt=0.
  - in_ready=0 while rst=1.
- Decode table (op[3:0]; unlisted controls are 0; alu_op=000 and sign_extend=00 unless stated):
  - NOP 0000: all 0.
  - SVPC 1111: reg_wrt, alu_to_reg, const_sel, pc_to_alu; alu_op 100; sext 01.
  - LOAD 1110: reg_wrt, mem_read.
  - STORE 0011: mem_write.
  - ADD 0100: reg_wrt, alu_to_reg; alu_op 100.
  - INC 0101: reg_wrt, alu_to_reg, const_sel; alu_op 100; sext 10.
  - NEG 0110: reg_wrt, alu_to_reg; alu_op 010.
  - SUB 0111: reg_wrt, alu_to_reg; alu_op 001.
  - J 1000: j.
  - BRZ 1001: branch.
  - BRN 1011: branch, br_neg.
  - JM 1010: mem_read, jm.
  - MAX 0001: mem_read, max_op.
  - 0010/1100/1101, or nonzero op[OP_W-1:4]: NOP controls, illegal=1, out_valid=1.
- Advance and accept:
  - adv = !out_valid | out_ready.
  - in_ready = !rst & !flush & adv & !hazard.
  - Accept = in_valid & in_ready. On accept the register loads the decoded bundle plus indices, out_valid=1, latency 1 cycle.
  - On adv without accept, the register loads all-zero controls and out_valid=0 (bubble).
  - When !adv the register and ld_age hold.
- Hazard tracking:
  - On accepting LOAD: ld_rd←rd, ld_age←LU_BUBBLES.
  - Otherwise ld_age decrements (floor 0) on each adv cycle.
  - hazard = ld_age≠0 & ((rs==ld_rd & op∉{NOP,SVPC,illegal}) | (rt==ld_rd & op∈{ADD,SUB,STORE,MAX})).
- Stall counter: stall_cnt increments on each cycle with in_valid & adv & hazard & !flush, and saturates at all-ones.
- Flush (priority below rst only):
  - Next edge: out_valid=0, controls 0, ld_age=0.
  - in_ready=0 in the flush cycle. A held bundle is dropped even if out_ready=0.
- Simultaneous events:
  - A LOAD accepted while ld_age≠0 with a hazard cannot occur (in_ready=0).
  - A LOAD accepted while ld_age≠0 without a hazard reloads ld_rd/ld_age.
  - Back-to-back independent instructions sustain 1 per cycle.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1, op=0100 → in_ready=0; all outputs 0 after release; first ADD appears with out_valid=1, reg_wrt=1, alu_op=100 one cycle after accept.
- Full decode sweep: issue all 16 opcodes with out_ready=1 → bundle matches table each cycle; 0010/1100/1101 give illegal=1; 1011 gives branch=1, br_neg=1; throughput 16 in 16 cycles.
- Load-use, LU_BUBBLES=1: LOAD rd=3, then ADD rs=3 → exactly one out_valid=0 cycle between them, stall_cnt=1. ADD rs=5 rt=6 instead → no bubble. With LU_BUBBLES=2 → two bubbles, stall_cnt=2.
- Backpressure: out_ready=0 for 4 cycles with ADD held → outputs stable, in_ready=0; LOAD held under backpressure does not age ld_age.
- Flush: flush=1 while SUB held and out_ready=0 → next cycle out_valid=0; pending load hazard cleared, so the dependent ADD is accepted in the following cycle with no bubble.
- Saturation: CNT_W=2, force 5 hazard cycles → stall_cnt=3.

Source files
------------

// File: rtl/ctrl_decode_stage.sv
// Registered decode stage: opcode -> control bundle behind a valid/ready pipeline register,
// with load-use hazard bubbles, flush from execute and a saturating stall counter.
module ctrl_decode_stage #(
  parameter int unsigned OP_W       = 4,
  parameter int unsigned REG_W      = 4,
  parameter int unsigned ALUOP_W    = 3,
  parameter int unsigned LU_BUBBLES = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    op,
  input  logic [REG_W-1:0]   rs,
  input  logic [REG_W-1:0]   rt,
  input  logic [REG_W-1:0]   rd,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               reg_wrt,
  output logic               mem_read,
  output logic               mem_write,
  output logic               branch,
  output logic               br_neg,
  output logic               j,
  output logic               alu_to_reg,
  output logic               const_sel,
  output logic               pc_to_alu,
  output logic               jm,
  output logic               max_op,
  output logic               illegal,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         sign_extend,
  output logic [REG_W-1:0]   rs_q,
  output logic [REG_W-1:0]   rt_q,
  output logic [REG_W-1:0]   rd_q,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam logic [3:0] OpNop   = 4'b0000;
  localparam logic [3:0] OpMax   = 4'b0001;
  localparam logic [3:0] OpStore = 4'b0011;
  localparam logic [3:0] OpAdd   = 4'b0100;
  localparam logic [3:0] OpInc   = 4'b0101;
  localparam logic [3:0] OpNeg   = 4'b0110;
  localparam logic [3:0] OpSub   = 4'b0111;
  localparam logic [3:0] OpJ     = 4'b1000;
  localparam logic [3:0] OpBrz   = 4'b1001;
  localparam logic [3:0] OpJm    = 4'b1010;
  localparam logic [3:0] OpBrn   = 4'b1011;
  localparam logic [3:0] OpLoad  = 4'b1110;
  localparam logic [3:0] OpSvpc  = 4'b1111;

  logic op_hi;
  if (OP_W > 4) begin : g_op_hi
    assign op_hi = |op[OP_W-1:4];
  end else begin : g_no_op_hi
    assign op_hi = 1'b0;
  end

  logic [3:0]         opc;
  logic               dec_rw, dec_mr, dec_mw, dec_br, dec_bn, dec_j;
  logic               dec_a2r, dec_cs, dec_p2a, dec_jm, dec_mx, dec_ill;
  logic [ALUOP_W-1:0] dec_alu;
  logic [1:0]         dec_sx;

  assign opc = op[3:0];

  always_comb begin
    dec_rw  = 1'b0;
    dec_mr  = 1'b0;
    dec_mw  = 1'b0;
    dec_br  = 1'b0;
    dec_bn  = 1'b0;
    dec_j   = 1'b0;
    dec_a2r = 1'b0;
    dec_cs  = 1'b0;
    dec_p2a = 1'b0;
    dec_jm  = 1'b0;
    dec_mx  = 1'b0;
    dec_ill = 1'b0;
    dec_alu = '0;
    dec_sx  = 2'b00;
    case (opc)
      OpNop: ;
      OpSvpc: begin
        dec_rw  = 1'b1;
        dec_a2r = 1'b1;
        dec_cs  = 1'b1;
        dec_p2a = 1'b1;
        dec_alu = ALUOP_W'(3'b100);
        dec_sx  = 2'b01;
      end
      OpLoad: begin
        dec_rw = 1'b1;
        dec_mr = 1'b1;
      end
      OpStore: dec_mw = 1'b1;
      OpAdd: begin
        dec_rw  = 1'b1;
        dec_a2r = 1'b1;
        dec_alu = ALUOP_W'(3'b100);
      end
      OpInc: begin
        dec_rw  = 1'b1;
        dec_a2r = 1'b1;
        dec_cs  = 1'b1;
        dec_alu = ALUOP_W'(3'b100);
        dec_sx  = 2'b10;
      end
      OpNeg: begin
        dec_rw  = 1'b1;
        dec_a2r = 1'b1;
        dec_alu = ALUOP_W'(3'b010);
      end
      OpSub: begin
        dec_rw  = 1'b1;
        dec_a2r = 1'b1;
        dec_alu = ALUOP_W'(3'b001);
      end
      OpJ:   dec_j = 1'b1;
      OpBrz: dec_br = 1'b1;
      OpBrn: begin
        dec_br = 1'b1;
        dec_bn = 1'b1;
      end
      OpJm: begin
        dec_mr = 1'b1;
        dec_jm = 1'b1;
      end
      OpMax: begin
        dec_mr = 1'b1;
        dec_mx = 1'b1;
      end
      default: dec_ill = 1'b1;
    endcase
    // Any set bit above the ISA opcode makes the instruction an illegal NOP.
    if (op_hi) begin
      dec_rw  = 1'b0;
      dec_mr  = 1'b0;
      dec_mw  = 1'b0;
      dec_br  = 1'b0;
      dec_bn  = 1'b0;
      dec_j   = 1'b0;
      dec_a2r = 1'b0;
      dec_cs  = 1'b0;
      dec_p2a = 1'b0;
      dec_jm  = 1'b0;
      dec_mx  = 1'b0;
      dec_ill = 1'b1;
      dec_alu = '0;
      dec_sx  = 2'b00;
    end
  end

  logic [REG_W-1:0] ld_rd;
  logic [2:0]       ld_age;
  logic             uses_rs, uses_rt, hazard, adv, accept, is_load, stall_inc;

  assign uses_rs  = !dec_ill && (opc != OpNop) && (opc != OpSvpc);
  assign uses_rt  = !dec_ill &&
                    ((opc == OpAdd) || (opc == OpSub) || (opc == OpStore) || (opc == OpMax));
  assign hazard   = (ld_age != 3'd0) &&
                    ((uses_rs && (rs == ld_rd)) || (uses_rt && (rt == ld_rd)));
  assign adv      = !out_valid || out_ready;
  assign in_ready = !rst && !flush && adv && !hazard;
  assign accept   = in_valid && in_ready;
  assign is_load  = !dec_ill && (opc == OpLoad);
  assign stall_inc = in_valid && adv && hazard && (stall_cnt != {CNT_W{1'b1}});

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid   <= 1'b0;
      reg_wrt     <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      branch      <= 1'b0;
      br_neg      <= 1'b0;
      j           <= 1'b0;
      alu_to_reg  <= 1'b0;
      const_sel   <= 1'b0;
      pc_to_alu   <= 1'b0;
      jm          <= 1'b0;
      max_op      <= 1'b0;
      illegal     <= 1'b0;
      alu_op      <= '0;
      sign_extend <= 2'b00;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      ld_age      <= 3'd0;
      if (rst) begin
        ld_rd     <= '0;
        stall_cnt <= '0;
      end
    end else begin
      if (stall_inc) stall_cnt <= stall_cnt + CNT_W'(1);
      if (adv) begin
        // Without an accept the register takes a bubble (all controls zero).
        out_valid   <= accept;
        reg_wrt     <= accept && dec_rw;
        mem_read    <= accept && dec_mr;
        mem_write   <= accept && dec_mw;
        branch      <= accept && dec_br;
        br_neg      <= accept && dec_bn;
        j           <= accept && dec_j;
        alu_to_reg  <= accept && dec_a2r;
        const_sel   <= accept && dec_cs;
        pc_to_alu   <= accept && dec_p2a;
        jm          <= accept && dec_jm;
        max_op      <= accept && dec_mx;
        illegal     <= accept && dec_ill;
        alu_op      <= accept ? dec_alu : '0;
        sign_extend <= accept ? dec_sx : 2'b00;
        rs_q        <= accept ? rs : '0;
        rt_q        <= accept ? rt : '0;
        rd_q        <= accept ? rd : '0;
        if (accept && is_load) begin
          ld_rd  <= rd;
          ld_age <= 3'(LU_BUBBLES);
        end else if (ld_age != 3'd0) begin
          ld_age <= ld_age - 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Directed bench for ctrl_decode_stage: decode table sweep plus hand-written hazard,
// backpressure, flush and counter-saturation sequences on two parameterisations.
module tb_ctrl_decode_stage;

  logic       clk = 1'b0;
  logic       rst, iv1, iv2, flush, out_ready;
  logic [3:0] op, rs, rt, rd;

  always #5 clk = ~clk;

  logic       ir1, ov1, rw1, mr1, mw1, br1, bn1, j1, a2r1, cs1, p2a1, jm1, mx1, ill1;
  logic [2:0] alu1;
  logic [1:0] sx1, st1;
  logic [3:0] rsq1, rtq1, rdq1;

  logic        ir2, ov2, rw2, mr2, mw2, br2, bn2, j2, a2r2, cs2, p2a2, jm2, mx2, ill2;
  logic [2:0]  alu2;
  logic [1:0]  sx2;
  logic [15:0] st2;
  logic [3:0]  rsq2, rtq2, rdq2;

  ctrl_decode_stage #(.OP_W(4), .REG_W(4), .ALUOP_W(3), .LU_BUBBLES(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .op(op), .rs(rs), .rt(rt), .rd(rd),
    .flush(flush), .out_valid(ov1), .out_ready(out_ready), .reg_wrt(rw1), .mem_read(mr1),
    .mem_write(mw1), .branch(br1), .br_neg(bn1), .j(j1), .alu_to_reg(a2r1), .const_sel(cs1),
    .pc_to_alu(p2a1), .jm(jm1), .max_op(mx1), .illegal(ill1), .alu_op(alu1),
    .sign_extend(sx1), .rs_q(rsq1), .rt_q(rtq1), .rd_q(rdq1), .stall_cnt(st1)
  );

  ctrl_decode_stage #(.OP_W(4), .REG_W(4), .ALUOP_W(3), .LU_BUBBLES(2), .CNT_W(16)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .op(op), .rs(rs), .rt(rt), .rd(rd),
    .flush(flush), .out_valid(ov2), .out_ready(out_ready), .reg_wrt(rw2), .mem_read(mr2),
    .mem_write(mw2), .branch(br2), .br_neg(bn2), .j(j2), .alu_to_reg(a2r2), .const_sel(cs2),
    .pc_to_alu(p2a2), .jm(jm2), .max_op(mx2), .illegal(ill2), .alu_op(alu2),
    .sign_extend(sx2), .rs_q(rsq2), .rt_q(rtq2), .rd_q(rdq2), .stall_cnt(st2)
  );

  // Bundle = {out_valid, 12 control bits, alu_op, sign_extend}
  logic [17:0] b1, b2;
  assign b1 = {ov1, rw1, mr1, mw1, br1, bn1, j1, a2r1, cs1, p2a1, jm1, mx1, ill1, alu1, sx1};
  assign b2 = {ov2, rw2, mr2, mw2, br2, bn2, j2, a2r2, cs2, p2a2, jm2, mx2, ill2, alu2, sx2};

  localparam logic [17:0] AddB  = {1'b1, 12'b1000_0010_0000, 3'b100, 2'b00};
  localparam logic [17:0] LoadB = {1'b1, 12'b1100_0000_0000, 3'b000, 2'b00};

  typedef struct {
    logic [3:0]  op;
    logic [11:0] ctl;
    logic [2:0]  alu;
    logic [1:0]  sx;
  } vec_t;

  vec_t tbl[16];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] o, input logic [3:0] s, input logic [3:0] t,
                        input logic [3:0] d);
    op = o;
    rs = s;
    rt = t;
    rd = d;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // {op, controls rw mr mw br bn j a2r cs p2a jm mx ill, alu_op, sext}
    tbl[0]  = '{4'b0000, 12'b0000_0000_0000, 3'b000, 2'b00};
    tbl[1]  = '{4'b0001, 12'b0100_0000_0010, 3'b000, 2'b00};
    tbl[2]  = '{4'b0010, 12'b0000_0000_0001, 3'b000, 2'b00};
    tbl[3]  = '{4'b0011, 12'b0010_0000_0000, 3'b000, 2'b00};
    tbl[4]  = '{4'b0100, 12'b1000_0010_0000, 3'b100, 2'b00};
    tbl[5]  = '{4'b0101, 12'b1000_0011_0000, 3'b100, 2'b10};
    tbl[6]  = '{4'b0110, 12'b1000_0010_0000, 3'b010, 2'b00};
    tbl[7]  = '{4'b0111, 12'b1000_0010_0000, 3'b001, 2'b00};
    tbl[8]  = '{4'b1000, 12'b0000_0100_0000, 3'b000, 2'b00};
    tbl[9]  = '{4'b1001, 12'b0001_0000_0000, 3'b000, 2'b00};
    tbl[10] = '{4'b1010, 12'b0100_0000_0100, 3'b000, 2'b00};
    tbl[11] = '{4'b1011, 12'b0001_1000_0000, 3'b000, 2'b00};
    tbl[12] = '{4'b1100, 12'b0000_0000_0001, 3'b000, 2'b00};
    tbl[13] = '{4'b1101, 12'b0000_0000_0001, 3'b000, 2'b00};
    tbl[14] = '{4'b1110, 12'b1100_0000_0000, 3'b000, 2'b00};
    tbl[15] = '{4'b1111, 12'b1000_0011_1000, 3'b100, 2'b01};

    // Reset with an ADD pending
    rst = 1'b1; iv1 = 1'b1; iv2 = 1'b1; flush = 1'b0; out_ready = 1'b1;
    set_in(4'b0100, 4'd1, 4'd2, 4'd3);
    #1;
    chk("rst_in_ready", 32'(ir1), 32'd0);
    tick();
    chk("rst_in_ready2", 32'(ir1), 32'd0);
    chk("rst_bundle", 32'(b1), 32'd0);
    chk("rst_stall", 32'(st1), 32'd0);
    tick();
    chk("rst_bundle_dut2", 32'(b2), 32'd0);
    chk("rst_idx", 32'({rsq1, rtq1, rdq1}), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(ir1), 32'd1);
    tick();
    chk("first_add", 32'(b1), 32'(AddB));
    chk("first_add_rs", 32'(rsq1), 32'd1);
    iv2 = 1'b0;

    // Decode sweep, one instruction per cycle
    for (int i = 0; i < 16; i++) begin
      set_in(tbl[i].op, 4'd1, 4'd2, 4'd3);
      #1;
      chk($sformatf("sweep_ready_%0d", i), 32'(ir1), 32'd1);
      tick();
      chk($sformatf("sweep_op_%0d", i), 32'(b1), 32'({1'b1, tbl[i].ctl, tbl[i].alu, tbl[i].sx}));
    end

    // Load-use, one bubble
    set_in(4'b1110, 4'd1, 4'd2, 4'd3);
    #1; tick();
    set_in(4'b0100, 4'd3, 4'd4, 4'd7);
    #1;
    chk("lu1_blocked", 32'(ir1), 32'd0);
    tick();
    chk("lu1_bubble", 32'(b1), 32'd0);
    chk("lu1_stall", 32'(st1), 32'd1);
    chk("lu1_ready", 32'(ir1), 32'd1);
    tick();
    chk("lu1_add", 32'(b1), 32'(AddB));
    chk("lu1_add_rs", 32'(rsq1), 32'd3);

    // Independent instruction after a load: no bubble
    set_in(4'b1110, 4'd1, 4'd2, 4'd3);
    #1; tick();
    set_in(4'b0100, 4'd5, 4'd6, 4'd7);
    #1;
    chk("indep_ready", 32'(ir1), 32'd1);
    tick();
    chk("indep_add", 32'(b1), 32'(AddB));
    chk("indep_rs", 32'(rsq1), 32'd5);
    chk("indep_stall", 32'(st1), 32'd1);

    // Load-use with two bubbles
    iv1 = 1'b0; iv2 = 1'b1;
    set_in(4'b1110, 4'd1, 4'd2, 4'd3);
    #1; tick();
    set_in(4'b0100, 4'd3, 4'd4, 4'd7);
    #1;
    chk("lu2_blocked", 32'(ir2), 32'd0);
    tick();
    chk("lu2_bubble1", 32'(ov2), 32'd0);
    tick();
    chk("lu2_bubble2", 32'(ov2), 32'd0);
    chk("lu2_stall", 32'(st2), 32'd2);
    chk("lu2_ready", 32'(ir2), 32'd1);
    tick();
    chk("lu2_add", 32'(b2), 32'(AddB));
    iv2 = 1'b0;

    // Backpressure: ADD held for 4 cycles
    iv1 = 1'b1;
    set_in(4'b0100, 4'd5, 4'd6, 4'd1);
    #1; tick();
    out_ready = 1'b0;
    set_in(4'b0111, 4'd1, 4'd2, 4'd4);
    #1;
    chk("bp_ready", 32'(ir1), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("bp_hold_%0d", k), 32'(b1), 32'(AddB));
      chk($sformatf("bp_hold_rs_%0d", k), 32'(rsq1), 32'd5);
    end
    // LOAD held under backpressure keeps its hazard age
    out_ready = 1'b1;
    set_in(4'b1110, 4'd1, 4'd2, 4'd9);
    #1; tick();
    chk("bp_load", 32'(b1), 32'(LoadB));
    out_ready = 1'b0;
    set_in(4'b0100, 4'd9, 4'd2, 4'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("bp_load_hold_%0d", k), 32'(b1), 32'(LoadB));
    end
    out_ready = 1'b1;
    #1;
    chk("bp_age_held", 32'(ir1), 32'd0);
    chk("bp_stall_no_adv", 32'(st1), 32'd1);
    tick();
    chk("bp_bubble", 32'(ov1), 32'd0);
    chk("bp_stall", 32'(st1), 32'd2);
    tick();
    chk("bp_add", 32'(b1), 32'(AddB));

    // Flush drops a held SUB and clears the pending load hazard
    iv1 = 1'b0; iv2 = 1'b1;
    set_in(4'b1110, 4'd1, 4'd2, 4'd3);
    #1; tick();
    set_in(4'b0111, 4'd1, 4'd2, 4'd4);
    #1;
    chk("fl_sub_ready", 32'(ir2), 32'd1);
    tick();
    chk("fl_sub_held", 32'(b2), 32'({1'b1, 12'b1000_0010_0000, 3'b001, 2'b00}));
    out_ready = 1'b0;
    flush = 1'b1;
    set_in(4'b0100, 4'd3, 4'd4, 4'd7);
    #1;
    chk("fl_ready", 32'(ir2), 32'd0);
    tick();
    flush = 1'b0;
    chk("fl_dropped", 32'(b2), 32'd0);
    out_ready = 1'b1;
    #1;
    chk("fl_no_hazard", 32'(ir2), 32'd1);
    tick();
    chk("fl_add", 32'(b2), 32'(AddB));
    chk("fl_add_rs", 32'(rsq2), 32'd3);
    chk("fl_stall", 32'(st2), 32'd2);
    iv2 = 1'b0;

    // Stall counter saturation on the 2-bit counter
    rst = 1'b1;
    tick();
    rst = 1'b0;
    iv1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_in(4'b1110, 4'd1, 4'd2, 4'd3);
      #1; tick();
      set_in(4'b0100, 4'd3, 4'd4, 4'd5);
      #1; tick();
      chk($sformatf("sat_%0d", i), 32'(st1), (i + 1 > 3) ? 32'd3 : 32'(i + 1));
      tick();
    end
    iv1 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
